// File: rtl/conv_enc_if.sv
// Handshake bundle for the K=7 convolutional encoder: bit stream in, code symbols out.
// The slave modport is the encoder side; master is the source/sink environment.
interface conv_enc_if;
  logic       in_bit;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_pair;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_bit, in_last, in_valid, out_ready,
    input  in_ready, out_pair, out_last, out_valid
  );

  modport slave (
    input  in_bit, in_last, in_valid, out_ready,
    output in_ready, out_pair, out_last, out_valid
  );
endinterface

// File: rtl/conv_enc_k7.sv
// Rate-1/2, K=7 convolutional encoder with a registered output stage and
// six zero tail bits appended after every frame so each frame ends in state 0.
module conv_enc_k7 #(
  parameter logic [6:0] G0 = 7'o171,
  parameter logic [6:0] G1 = 7'o133
) (
  input  logic      clk,
  input  logic      rst_n,
  conv_enc_if.slave bus
);

  typedef enum logic {StData, StTail} state_e;

  state_e     state_q, state_d;
  logic [5:0] s_q, s_d;
  logic [2:0] tail_cnt_q, tail_cnt_d;
  logic [1:0] pair_q, pair_d;
  logic       last_q, last_d;
  logic       valid_q, valid_d;

  logic       slot_free;
  logic       load;
  logic       u;
  logic [6:0] w;

  always_comb begin
    slot_free    = !valid_q || bus.out_ready;
    state_d      = state_q;
    s_d          = s_q;
    tail_cnt_d   = tail_cnt_q;
    pair_d       = pair_q;
    last_d       = last_q;
    valid_d      = valid_q;
    load         = 1'b0;
    u            = 1'b0;
    bus.in_ready = 1'b0;

    unique case (state_q)
      StData: begin
        bus.in_ready = slot_free;
        u            = bus.in_bit;
        if (bus.in_valid && slot_free) begin
          load   = 1'b1;
          last_d = 1'b0;
          if (bus.in_last) begin
            state_d    = StTail;
            tail_cnt_d = 3'd0;
          end
        end
      end
      StTail: begin
        if (slot_free) begin
          load       = 1'b1;
          tail_cnt_d = tail_cnt_q + 3'd1;
          last_d     = 1'b0;
          if (tail_cnt_q == 3'd5) begin
            last_d     = 1'b1;
            state_d    = StData;
            tail_cnt_d = 3'd0;
          end
        end
      end
    endcase

    w = {u, s_q};
    if (load) begin
      pair_d  = {^(w & G0), ^(w & G1)};
      valid_d = 1'b1;
      s_d     = w[6:1];
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StData;
      s_q        <= '0;
      tail_cnt_q <= '0;
      pair_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      tail_cnt_q <= tail_cnt_d;
      pair_q     <= pair_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.out_pair  = pair_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;

endmodule
